// File: rtl/mul_arb_i8.sv
// mul_arb_i8 -- N_REQ requesters share one signed multiplier through a
// round-robin arbiter feeding a 2-stage valid/ready pipeline.
//
// Ports:
//   i_clk        clock, all state on rising edge
//   i_rst_n      asynchronous active-low reset
//   i_req_valid  per-requester valid
//   i_req_op0/1  per-requester signed operands, requester k at [k*bit_width +: bit_width]
//   o_req_ready  one-hot (or zero) accept strobe
//   o_res_valid  result presented
//   o_res_prd    signed product
//   o_res_id     index of the requester owning o_res_prd
//   i_res_ready  consumer accepts the result
module mul_arb_i8 #(
  parameter int N_REQ     = 4,
  parameter int bit_width = 8,
  parameter int prd_width = 2*bit_width,
  localparam int id_width = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [N_REQ-1:0]             i_req_valid,
  input  logic [N_REQ*bit_width-1:0]   i_req_op0,
  input  logic [N_REQ*bit_width-1:0]   i_req_op1,
  output logic [N_REQ-1:0]             o_req_ready,
  output logic                         o_res_valid,
  output logic [prd_width-1:0]         o_res_prd,
  output logic [id_width-1:0]          o_res_id,
  input  logic                         i_res_ready
);

  localparam int unsigned NR = N_REQ;

  logic [id_width-1:0]         ptr;

  logic                        s1_valid;
  logic signed [bit_width-1:0] s1_op0;
  logic signed [bit_width-1:0] s1_op1;
  logic [id_width-1:0]         s1_id;

  logic                        s2_valid;
  logic signed [prd_width-1:0] s2_prd;
  logic [id_width-1:0]         s2_id;

  logic                        adv1;
  logic                        adv2;
  logic                        gnt_found;
  logic                        grant;
  logic [id_width-1:0]         gnt_id;
  logic [bit_width-1:0]        gnt_op0;
  logic [bit_width-1:0]        gnt_op1;

  logic signed [prd_width-1:0] op0_ext;
  logic signed [prd_width-1:0] op1_ext;
  logic signed [prd_width-1:0] prd_c;

  assign adv2 = !s2_valid || i_res_ready;
  assign adv1 = !s1_valid || adv2;

  // Round-robin search done as two linear passes: first the requesters at or
  // above ptr, then wrap to the bottom. Keeps every index a loop constant.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    gnt_op0   = '0;
    gnt_op1   = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      if (!gnt_found && i_req_valid[k] && (k >= 32'(ptr))) begin
        gnt_found = 1'b1;
        gnt_id    = id_width'(k);
        gnt_op0   = i_req_op0[k*bit_width +: bit_width];
        gnt_op1   = i_req_op1[k*bit_width +: bit_width];
      end
    end
    for (int unsigned k = 0; k < NR; k++) begin
      if (!gnt_found && i_req_valid[k]) begin
        gnt_found = 1'b1;
        gnt_id    = id_width'(k);
        gnt_op0   = i_req_op0[k*bit_width +: bit_width];
        gnt_op1   = i_req_op1[k*bit_width +: bit_width];
      end
    end
  end

  // Ready is also held low while reset is asserted.
  assign grant = gnt_found && adv1 && i_rst_n;

  always_comb begin
    o_req_ready = '0;
    if (grant) o_req_ready[gnt_id] = 1'b1;
  end

  // Sign-extend to the product width first so the multiply is exact.
  assign op0_ext = prd_width'(s1_op0);
  assign op1_ext = prd_width'(s1_op1);
  assign prd_c   = op0_ext * op1_ext;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_op0   <= '0;
      s1_op1   <= '0;
      s1_id    <= '0;
      s2_valid <= 1'b0;
      s2_prd   <= '0;
      s2_id    <= '0;
    end else begin
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_prd <= prd_c;
          s2_id  <= s1_id;
        end
      end
      if (adv1) begin
        s1_valid <= grant;
        if (grant) begin
          s1_op0 <= gnt_op0;
          s1_op1 <= gnt_op1;
          s1_id  <= gnt_id;
        end
      end
      if (grant) begin
        if (32'(gnt_id) == NR - 1) ptr <= '0;
        else                       ptr <= gnt_id + id_width'(1);
      end
    end
  end

  assign o_res_valid = s2_valid;
  assign o_res_prd   = s2_prd;
  assign o_res_id    = s2_id;

endmodule

// File: tb/tb_mul_arb_i8.sv
// Directed bench for mul_arb_i8 (N_REQ=4, 8-bit operands) with a cycle
// model of the arbiter/pipeline and a scoreboard of expected results.
module tb_mul_arb_i8;

  localparam int N = 4;
  localparam int W = 8;
  localparam int P = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] op0 = '0;
  logic [N*W-1:0] op1 = '0;
  logic [N-1:0]   req_ready;
  logic           res_valid;
  logic [P-1:0]   res_prd;
  logic [1:0]     res_id;
  logic           res_ready = 1'b1;

  mul_arb_i8 #(.N_REQ(N), .bit_width(W), .prd_width(P)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_op0   (op0),
    .i_req_op1   (op1),
    .o_req_ready (req_ready),
    .o_res_valid (res_valid),
    .o_res_prd   (res_prd),
    .o_res_id    (res_id),
    .i_res_ready (res_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           id;
    logic [P-1:0] prd;
  } exp_t;

  exp_t q[$];
  int   out_ids[$];
  int   out_prds[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic m_s1v = 1'b0;
  logic m_s2v = 1'b0;
  int   m_ptr = 0;
  int   n_acc = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_op(input int k, input int a, input int b);
    logic [W-1:0] av;
    logic [W-1:0] bv;
    av = W'(a);
    bv = W'(b);
    op0[k*W +: W] = av;
    op1[k*W +: W] = bv;
  endtask

  task automatic model_clear();
    q.delete();
    m_s1v = 1'b0;
    m_s2v = 1'b0;
    m_ptr = 0;
  endtask

  // One clock cycle: check at the falling edge, then step the model across
  // the rising edge and return 1 time unit after it.
  task automatic cyc();
    logic [N-1:0]        exp_rdy;
    logic                adv1;
    logic                adv2;
    int                  g;
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    int                  p;
    exp_t                e;
    @(negedge clk);
    exp_rdy = '0;
    g = -1;
    adv2 = !m_s2v || res_ready;
    adv1 = !m_s1v || adv2;
    if (rst_n && adv1) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (g < 0 && req_valid[k]) g = k;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("res_valid", 32'(res_valid), 32'(m_s2v));
    if (req_ready != '0 && (req_ready & req_valid) != '0) n_acc++;
    if (m_s2v) begin
      if (q.size() == 0) begin
        chk("sb_underflow", 32'(q.size()), 32'd1);
      end else begin
        chk("res_prd", 32'(res_prd), 32'(q[0].prd));
        chk("res_id", 32'(res_id), 32'(q[0].id));
        if (res_ready) begin
          void'(q.pop_front());
          out_ids.push_back(int'(res_id));
          out_prds.push_back(int'($signed(res_prd)));
        end
      end
    end
    if (g >= 0) begin
      a = op0[g*W +: W];
      b = op1[g*W +: W];
      p = int'(a) * int'(b);
      e.id  = g;
      e.prd = p[P-1:0];
      q.push_back(e);
    end
    @(posedge clk);
    if (rst_n) begin
      if (adv2) m_s2v = m_s1v;
      if (adv1) m_s1v = (g >= 0);
      if (g >= 0) m_ptr = (g + 1) % N;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_prd", 32'(res_prd), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    req_valid = '1;
    #1;
    chk("rst_ready_low", 32'(req_ready), 32'd0);
    req_valid = '0;
    cyc();
    cyc();
    rst_n = 1'b1;

    // Single request on requester 2: -3 * 7
    set_op(2, -3, 7);
    req_valid = 4'b0100;
    cyc();
    req_valid = '0;
    cyc();
    cyc();
    idle(2);

    // All four valid from reset: grants and results 0,1,2,3,0
    do_reset();
    out_ids.delete();
    set_op(0, 5, -6);
    set_op(1, -11, -12);
    set_op(2, 100, 3);
    set_op(3, -1, 127);
    req_valid = '1;
    for (int i = 0; i < 5; i++) cyc();
    idle(3);
    chk("rr_count", 32'(out_ids.size()), 32'd5);
    if (out_ids.size() == 5) begin
      chk("rr_id0", 32'(out_ids[0]), 32'd0);
      chk("rr_id1", 32'(out_ids[1]), 32'd1);
      chk("rr_id2", 32'(out_ids[2]), 32'd2);
      chk("rr_id3", 32'(out_ids[3]), 32'd3);
      chk("rr_id4", 32'(out_ids[4]), 32'd0);
    end

    // Multiplier corners through requester 0
    out_prds.delete();
    req_valid = 4'b0001;
    set_op(0, -128, -128); cyc();
    set_op(0, -128, 127);  cyc();
    set_op(0, 127, 127);   cyc();
    set_op(0, 0, -128);    cyc();
    idle(3);
    chk("corner_count", 32'(out_prds.size()), 32'd4);
    if (out_prds.size() == 4) begin
      chk("corner_m128_m128", 32'(out_prds[0]), 32'd16384);
      chk("corner_m128_127", 32'(out_prds[1]), 32'(-16256));
      chk("corner_127_127", 32'(out_prds[2]), 32'd16129);
      chk("corner_0_m128", 32'(out_prds[3]), 32'd0);
    end

    // Backpressure: 5 stalled cycles accept exactly two, then drain in order
    set_op(0, 9, 9);
    set_op(1, -7, 8);
    set_op(2, 12, -12);
    set_op(3, 2, 64);
    out_ids.delete();
    res_ready = 1'b0;
    req_valid = '1;
    n_acc = 0;
    for (int i = 0; i < 5; i++) cyc();
    chk("stall_accepts", 32'(n_acc), 32'd2);
    res_ready = 1'b1;
    idle(4);
    chk("stall_drained", 32'(out_ids.size()), 32'd2);

    // Async reset with both stages full
    do_reset();
    res_ready = 1'b0;
    req_valid = '1;
    cyc();
    cyc();
    cyc();
    chk("pre_rst_full", 32'(res_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_res_valid", 32'(res_valid), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    chk("arst_res_prd", 32'(res_prd), 32'd0);
    chk("arst_res_id", 32'(res_id), 32'd0);
    model_clear();
    cyc();
    rst_n = 1'b1;
    res_ready = 1'b1;
    #1;
    chk("post_rst_grant0", 32'(req_ready), 32'd1);
    cyc();
    cyc();
    idle(3);

    // Only 1 and 3 valid with ptr at 2: grants alternate 3,1,3,1
    do_reset();
    out_ids.delete();
    set_op(1, 4, -4);
    set_op(3, -9, -9);
    req_valid = 4'b0010;
    cyc();
    req_valid = 4'b1010;
    for (int i = 0; i < 4; i++) cyc();
    idle(3);
    chk("alt_count", 32'(out_ids.size()), 32'd5);
    if (out_ids.size() == 5) begin
      chk("alt_id0", 32'(out_ids[0]), 32'd1);
      chk("alt_id1", 32'(out_ids[1]), 32'd3);
      chk("alt_id2", 32'(out_ids[2]), 32'd1);
      chk("alt_id3", 32'(out_ids[3]), 32'd3);
      chk("alt_id4", 32'(out_ids[4]), 32'd1);
    end

    // Randomised traffic with random backpressure
    for (int i = 0; i < 200; i++) begin
      for (int k = 0; k < N; k++) set_op(k, int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
      req_valid = N'($urandom_range(15));
      res_ready = ($urandom_range(3) != 0);
      cyc();
    end
    res_ready = 1'b1;
    idle(4);
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_arb_i8.md
MUL_ARB_I8 -- requirements
Module: mul_arb_i8

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning the number of requesters sharing one signed multiplier (legal range 2..16).
REQ-002 SHALL have parameter bit_width, default 8, meaning the signed operand width.
REQ-003 SHALL have parameter prd_width, default 2*bit_width, meaning the signed product width.
REQ-004 SHALL have derived parameter id_width = max(1, clog2(N_REQ)).
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port i_req_valid, input, N_REQ bits: bit k high means requester k presents an operand pair.
REQ-008 SHALL have port i_req_op0, input, N_REQ*bit_width bits: requester k's signed operand 0 at [k*bit_width +: bit_width].
REQ-009 SHALL have port i_req_op1, input, N_REQ*bit_width bits: requester k's signed operand 1, same packing.
REQ-010 SHALL have port o_req_ready, output, N_REQ bits: one-hot or zero; bit k high means requester k's pair is accepted this cycle.
REQ-011 SHALL have port o_res_valid, output, 1 bit: a result is presented.
REQ-012 SHALL have port o_res_prd, output, prd_width bits: signed product.
REQ-013 SHALL have port o_res_id, output, id_width bits: index of the requester that owns o_res_prd.
REQ-014 SHALL have port i_res_ready, input, 1 bit: consumer accepts the result when high with o_res_valid.

Function
REQ-015 SHALL implement a 2-stage pipeline: S1 registers operands and id; S2 registers product and id; S2 drives o_res_*.
REQ-016 SHALL transfer a request on requester k when i_req_valid[k] and o_req_ready[k] are both high; a result transfers when o_res_valid and i_res_ready are both high.
REQ-017 SHALL compute advance conditions: adv2 = !S2.valid || i_res_ready; adv1 = !S1.valid || adv2.
REQ-018 SHALL assert at most one o_req_ready bit, only when adv1 is high, to the first requester with valid high searching upward from pointer ptr with wrap-around.
REQ-019 SHALL drive o_req_ready combinationally from i_req_valid, ptr and pipeline state; no ready bit SHALL be asserted for a requester whose valid is low.
REQ-020 SHALL, on a grant to k, set ptr to (k+1) mod N_REQ; with no grant, ptr SHALL hold.
REQ-021 SHALL compute o_res_prd as the exact signed two's-complement product of the S1 operands, sign-correct for all inputs including -128*-128 = 16384 and -128*127 = -16256.
REQ-022 SHALL give latency of exactly 2 cycles from request transfer edge to o_res_valid high when i_res_ready is held high, and sustain one result per cycle.
REQ-023 SHALL hold o_res_valid, o_res_prd and o_res_id stable while o_res_valid is high and i_res_ready is low.
REQ-024 SHALL, under backpressure, stall S2 then S1, accept no new requests once both hold data, and lose or duplicate no result.
REQ-025 SHALL, when S2 drains and S1 refills in the same cycle, move S1 to S2 and load the new grant into S1 in that edge.
REQ-026 SHALL deliver results in grant order; o_res_id SHALL equal the granted index.
REQ-027 SHALL be such that a requester's valid dropping without a grant has no effect on state.

Reset
REQ-028 SHALL, on i_rst_n low, asynchronously clear S1.valid and S2.valid, set ptr to 0, o_res_prd to 0 and o_res_id to 0, with o_res_valid and all o_req_ready bits low.
REQ-029 SHALL discard in-flight results when reset asserts mid-operation; first grant after release SHALL search from requester 0.

Verification
REQ-030 SHALL cover: after reset, req 2 valid, op0=-3, op1=7, i_res_ready=1 -> ready[2] in cycle 0, o_res_valid in cycle 2 with prd=-21, id=2.
REQ-031 SHALL cover: all 4 valid continuously, i_res_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, results id order 0,1,2,3,0 one per cycle.
REQ-032 SHALL cover: corners -128*-128, -128*127, 127*127, 0*-128 -> 16384, -16256, 16129, 0.
REQ-033 SHALL cover: i_res_ready low 5 cycles with requests pending -> exactly 2 accepts then ready all-zero, o_res_* stable; on release results drain in order with no loss.
REQ-034 SHALL cover: reset asserted with S1 and S2 full -> o_res_valid low immediately, no stale result after release, ptr=0.
REQ-035 SHALL cover: only req 1 and 3 valid, ptr=2 -> grant 3 then 1 alternating.
